i2c_line_conditioner: RTL and testbench
=======================================

# i2c_line_conditioner

Parametrised input conditioner for the I2C peripheral's bus lines (SCL, SDA, and any extra sideband inputs). Each channel passes through an N-stage synchroniser, a consecutive-sample glitch filter, and a registered output with true and complement forms. Optional one-cycle rise/fall pulses are produced from the filtered value. It sits between the pads and the I2C bit/byte FSMs, replacing ad-hoc single flip-flops on the bus inputs.

## Interface
- WIDTH, 2: number of independent channels (bit 0 = SCL, bit 1 = SDA by convention); min 1.
- STAGES, 2: synchroniser depth; min 2.
- FILTER_CYCLES, 4: consecutive synchronised samples required to accept a new level; min 1.
- RESET_VAL, {WIDTH{1'b1}}: per-channel reset level (I2C idle high).

- clk_in  input  1  single system clock, all logic on posedge.
- rst_n_in  input  1  asynchronous, active-low reset.
- d_in  input  WIDTH  raw asynchronous line levels.
- q_out  output  WIDTH  filtered line level.
- q_bar_out  output  WIDTH  complement of q_out.
- rise_out  output  WIDTH  one-cycle pulse on accepted 0->1 of q_out.
- fall_out  output  WIDTH  one-cycle pulse on accepted 1->0 of q_out.

## Operation
- Reset: one clock, `clk_in`; reset `rst_n_in` is asynchronous and active-low. While it is asserted, all sync stages = RESET_VAL, q_out = RESET_VAL, q_bar_out = ~RESET_VAL, rise_out = fall_out = 0, all counters = 0.
- Per channel i, fully independent:
  - Sync chain: STAGES flops, stage 0 samples d_in[i]. s = last stage output.
  - Filter counter cnt, width $clog2(FILTER_CYCLES+1):
    - If s == q_out[i]: cnt <= 0.
    - Else if cnt == FILTER_CYCLES-1: q_out[i] <= s, q_bar_out[i] <= ~s, cnt <= 0.
    - Else: cnt <= cnt+1.
  - Counter is cleared, not decremented, when s returns to q_out[i]. A pulse on s shorter than FILTER_CYCLES cycles never reaches q_out.
- q_bar_out is registered on the same edge as q_out. It is always the exact complement and never lags by a cycle.
- Edge pulses, registered on the same edge as the q_out update:
  - rise_out[i] <= accept && s.
  - fall_out[i] <= accept && !s.
  - Both outputs are high for exactly one cycle, and never both high at once on one channel.
- Simultaneous transitions on several channels are handled independently with identical latency. Skew across channels of at most one sample is preserved, not aligned.

## Timing
- Accept latency: d_in change settled before edge 1 gives s new at edge STAGES, and q_out/q_bar_out/edge pulse update at edge STAGES+FILTER_CYCLES. Defaults: edge 6.
- Minimum accepted pulse width at d_in: FILTER_CYCLES clk_in cycles, with STAGES-cycle metastability margin.
- Reset mid-filter: counter and all state return to reset values immediately. After release, the filter needs a full FILTER_CYCLES agreement again. No edge pulse is generated by reset or its release.
- d_in equal to RESET_VAL at release: no q_out activity.

## Configuration
- Macro I2C_COND_EDGE_DET_EN:
  - Defined: rise_out/fall_out are generated as above.
  - Undefined: edge registers are not built, and rise_out and fall_out are tied to 0. q_out/q_bar_out behaviour is unchanged.

## Test plan
- Reset: hold rst_n_in=0 with d_in=2'b00. Required: q_out=2'b11, q_bar_out=2'b00, rise_out=fall_out=0. After release with d_in=2'b11, no pulses for 20 cycles.
- Clean fall (defaults): d_in[0] 1->0 before edge 1. Required: q_out[0]=0 and q_bar_out[0]=1 after edge 6, fall_out[0]=1 only in the cycle after edge 6, q_out[1] unchanged.
- Glitch reject: d_in[1] low for 3 cycles, then high. Required: q_out[1] stays 1, no fall_out pulse.
- Glitch accept: d_in[1] low for exactly 4 cycles. Required: fall_out[1] after edge 6; q_out[1] returns to 1 four cycles later with a rise_out[1] pulse.
- Reset mid-filter: d_in[0]=0, assert rst_n_in after edge 4 for 2 cycles, keep d_in[0]=0. Required: q_out[0]=1 during reset, then falls 6 edges after release.
- Macro undefined: repeat the clean-fall test. Required: identical q_out timing, and rise_out/fall_out constantly 0.

Source files
------------

// File: rtl/i2c_line_conditioner.sv
// Bus-line conditioner: per-channel N-stage synchroniser, consecutive-sample glitch filter, registered true/complement outputs.
// Latency: a settled d_in change reaches q_out at edge STAGES+FILTER_CYCLES; edge pulses update on that same edge.
// Backpressure: none, free-running on every clock. Optional rise/fall pulses are built only with I2C_COND_EDGE_DET_EN.
module i2c_line_conditioner #(
  parameter int                 WIDTH         = 2,
  parameter int                 STAGES        = 2,
  parameter int                 FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL     = {WIDTH{1'b1}}
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] q_bar_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out
);

  localparam int             CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] r_sync [STAGES];
  logic [CW-1:0]    r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_bar;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_accept;

  assign w_s = r_sync[STAGES-1];

  // Synchroniser chain: stage 0 samples the raw pad level, the last stage feeds the filter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < STAGES; k++) r_sync[k] <= RESET_VAL;
    end else begin
      r_sync[0] <= d_in;
      for (int k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  // A channel accepts its new level once it has disagreed with q for FILTER_CYCLES samples in a row.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = (w_s[i] != r_q[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  // Filter counters and output level; the counter is cleared (not decremented) whenever s agrees with q.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      r_q     <= RESET_VAL;
      r_q_bar <= ~RESET_VAL;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_s[i] == r_q[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_q[i]     <= w_s[i];
          r_q_bar[i] <= ~w_s[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign q_out     = r_q;
  assign q_bar_out = r_q_bar;

`ifdef I2C_COND_EDGE_DET_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  // One-cycle edge pulses registered on the same edge as the q_out update; accept and s make them exclusive.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_accept & w_s;
      r_fall <= w_accept & ~w_s;
    end
  end

  assign rise_out = r_rise;
  assign fall_out = r_fall;
`else
  assign rise_out = '0;
  assign fall_out = '0;
`endif

endmodule

// File: tb/tb_i2c_line_conditioner.sv
module tb_i2c_line_conditioner;

  logic       clk_in;
  logic       rst_n_in;
  logic [1:0] d_in;
  logic [1:0] q_out;
  logic [1:0] q_bar_out;
  logic [1:0] rise_out;
  logic [1:0] fall_out;

  int checks;
  int errors;

`ifdef I2C_COND_EDGE_DET_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  i2c_line_conditioner #(
    .WIDTH(2), .STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(2'b11)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .d_in(d_in),
    .q_out(q_out), .q_bar_out(q_bar_out), .rise_out(rise_out), .fall_out(fall_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Steps one edge and samples 1 time unit later.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    d_in     = 2'b00;
    repeat (3) step();
    checks++; if (q_out !== 2'b11) begin errors++; $display("FAIL reset_q got %b want 11", q_out); end
    checks++; if (q_bar_out !== 2'b00) begin errors++; $display("FAIL reset_qbar got %b want 00", q_bar_out); end
    checks++; if (rise_out !== 2'b00 || fall_out !== 2'b00) begin errors++; $display("FAIL reset_pulses got rise %b fall %b want 00 00", rise_out, fall_out); end
    @(negedge clk_in);
    d_in     = 2'b11;
    rst_n_in = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      checks++;
      if (q_out !== 2'b11 || rise_out !== 2'b00 || fall_out !== 2'b00) begin
        errors++; $display("FAIL release_quiet edge %0d got q %b rise %b fall %b want 11 00 00", e, q_out, rise_out, fall_out);
      end
    end
  endtask

  // Channel 0 falls; checks latency, complement, pulse placement and channel 1 isolation.
  task automatic test_clean_fall();
    logic       exp_q0;
    logic [1:0] exp_fall;
    @(negedge clk_in);
    d_in[0] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp_q0   = (e >= 6) ? 1'b0 : 1'b1;
      exp_fall = (EDGE_EN && e == 6) ? 2'b01 : 2'b00;
      checks++; if (q_out !== {1'b1, exp_q0}) begin errors++; $display("FAIL fall_q edge %0d got %b want %b", e, q_out, {1'b1, exp_q0}); end
      checks++; if (q_bar_out !== {1'b0, ~exp_q0}) begin errors++; $display("FAIL fall_qbar edge %0d got %b want %b", e, q_bar_out, {1'b0, ~exp_q0}); end
      checks++; if (fall_out !== exp_fall || rise_out !== 2'b00) begin errors++; $display("FAIL fall_pulse edge %0d got fall %b rise %b want %b 00", e, fall_out, rise_out, exp_fall); end
    end
  endtask

  // Channel 0 returns high; rise pulse at edge 6.
  task automatic test_clean_rise();
    logic       exp_q0;
    logic [1:0] exp_rise;
    @(negedge clk_in);
    d_in[0] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp_q0   = (e >= 6) ? 1'b1 : 1'b0;
      exp_rise = (EDGE_EN && e == 6) ? 2'b01 : 2'b00;
      checks++; if (q_out !== {1'b1, exp_q0} || q_bar_out !== {1'b0, ~exp_q0}) begin errors++; $display("FAIL rise_q edge %0d got q %b qbar %b want %b", e, q_out, q_bar_out, {1'b1, exp_q0}); end
      checks++; if (rise_out !== exp_rise || fall_out !== 2'b00) begin errors++; $display("FAIL rise_pulse edge %0d got rise %b fall %b want %b 00", e, rise_out, fall_out, exp_rise); end
    end
  endtask

  task automatic test_glitch_reject();
    @(negedge clk_in);
    d_in[1] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 3) begin @(negedge clk_in); d_in[1] = 1'b1; end
      checks++;
      if (q_out !== 2'b11 || fall_out !== 2'b00 || rise_out !== 2'b00) begin
        errors++; $display("FAIL glitch_reject edge %0d got q %b fall %b rise %b want 11 00 00", e, q_out, fall_out, rise_out);
      end
    end
  endtask

  // Four-cycle low pulse: accepted fall at edge 6, rise accepted four edges later at edge 10.
  task automatic test_glitch_accept();
    logic       exp_q1;
    logic [1:0] exp_fall;
    logic [1:0] exp_rise;
    @(negedge clk_in);
    d_in[1] = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (e == 4) begin @(negedge clk_in); d_in[1] = 1'b1; #0; end
      exp_q1   = (e >= 6 && e < 10) ? 1'b0 : 1'b1;
      exp_fall = (EDGE_EN && e == 6)  ? 2'b10 : 2'b00;
      exp_rise = (EDGE_EN && e == 10) ? 2'b10 : 2'b00;
      checks++; if (q_out !== {exp_q1, 1'b1} || q_bar_out !== {~exp_q1, 1'b0}) begin errors++; $display("FAIL glitch_accept_q edge %0d got q %b qbar %b want %b", e, q_out, q_bar_out, {exp_q1, 1'b1}); end
      checks++; if (fall_out !== exp_fall || rise_out !== exp_rise) begin errors++; $display("FAIL glitch_accept_pulse edge %0d got fall %b rise %b want %b %b", e, fall_out, rise_out, exp_fall, exp_rise); end
    end
  endtask

  task automatic test_reset_mid_filter();
    logic       exp_q0;
    logic [1:0] exp_fall;
    @(negedge clk_in);
    d_in[0] = 1'b0;
    repeat (4) step();
    checks++; if (q_out !== 2'b11) begin errors++; $display("FAIL midfilter_pre got %b want 11", q_out); end
    rst_n_in = 1'b0;
    #1;
    checks++; if (q_out !== 2'b11 || q_bar_out !== 2'b00 || fall_out !== 2'b00) begin errors++; $display("FAIL midfilter_in_reset got q %b qbar %b fall %b want 11 00 00", q_out, q_bar_out, fall_out); end
    repeat (2) step();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      exp_q0   = (e >= 6) ? 1'b0 : 1'b1;
      exp_fall = (EDGE_EN && e == 6) ? 2'b01 : 2'b00;
      checks++; if (q_out !== {1'b1, exp_q0} || fall_out !== exp_fall || rise_out !== 2'b00) begin errors++; $display("FAIL midfilter_post edge %0d got q %b fall %b rise %b want %b %b 00", e, q_out, fall_out, rise_out, {1'b1, exp_q0}, exp_fall); end
    end
    @(negedge clk_in);
    d_in[0] = 1'b1;
    repeat (8) step();
  endtask

  // Both channels fall together and must update on the same edge.
  task automatic test_back_to_back();
    logic [1:0] exp_q;
    logic [1:0] exp_fall;
    @(negedge clk_in);
    d_in = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_q    = (e >= 6) ? 2'b00 : 2'b11;
      exp_fall = (EDGE_EN && e == 6) ? 2'b11 : 2'b00;
      checks++; if (q_out !== exp_q || q_bar_out !== ~exp_q || fall_out !== exp_fall) begin errors++; $display("FAIL both_fall edge %0d got q %b qbar %b fall %b want %b %b", e, q_out, q_bar_out, fall_out, exp_q, exp_fall); end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n_in = 1'b0;
    d_in     = 2'b11;
    test_reset();
    test_clean_fall();
    test_clean_rise();
    test_glitch_reject();
    test_glitch_accept();
    test_reset_mid_filter();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
